// File: rtl/dmem_if.sv
// Load/store port between the core (master) and a handshaked data memory (slave).
// Request and response channels each use a valid/ready handshake.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data memory responder: one request at a time, LATENCY wait states, then RV32I B/H/W access.
// Define DMEM_MISALIGN_CHK_EN to reject misaligned H/HU/W requests instead of aligning them down.
module dmem_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam int         DEPTH = 1 << (ADDR_WIDTH - 2);
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              wait_cnt;
    logic                    lat_we;
    logic [2:0]              lat_funct3;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [31:0]             lat_wdata;
    logic [31:0]             rdata_q;
    logic                    err_q;

    logic [31:0]             mem [DEPTH];
    logic [ADDR_WIDTH-3:0]   word_idx;
    logic [1:0]              lane;
    logic [31:0]             mem_word;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [31:0]             load_data;
    logic [3:0]              be;
    logic [31:0]             wr_data;
    logic                    illegal;
    logic                    access;
    logic                    do_write;

    assign word_idx = lat_addr[ADDR_WIDTH-1:2];
    assign lane     = lat_addr[1:0];
    assign access   = (state == WAIT) && (wait_cnt == 4'd0);
    assign do_write = access && lat_we && !illegal;

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_next = WAIT;
            end
            WAIT: begin
                if (wait_cnt == 4'd0) state_next = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Decode the latched request: legality, load extraction and store lane enables.
    always_comb begin
        mem_word = mem[word_idx];
        illegal  = 1'b0;
        case (lat_funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = lat_we;
            default:                illegal = 1'b1;
        endcase
`ifdef DMEM_MISALIGN_CHK_EN
        if ((lat_funct3[1:0] == 2'b01 && lane[0]) ||
            (lat_funct3 == 3'b010 && lane != 2'b00)) begin
            illegal = 1'b1;
        end
`endif
        case (lane)
            2'd0:    byte_sel = mem_word[7:0];
            2'd1:    byte_sel = mem_word[15:8];
            2'd2:    byte_sel = mem_word[23:16];
            default: byte_sel = mem_word[31:24];
        endcase
        half_sel = lane[1] ? mem_word[31:16] : mem_word[15:0];
        case (lat_funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = mem_word;
        endcase
        case (lat_funct3[1:0])
            2'b00: begin
                be      = 4'b0001 << lane;
                wr_data = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                be      = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{lat_wdata[15:0]}};
            end
            default: begin
                be      = 4'b1111;
                wr_data = lat_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt   <= 4'd0;
            lat_we     <= 1'b0;
            lat_funct3 <= 3'd0;
            lat_addr   <= '0;
            lat_wdata  <= 32'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_we     <= bus.req_we;
                        lat_funct3 <= bus.req_funct3;
                        lat_addr   <= bus.req_addr[ADDR_WIDTH-1:0];
                        lat_wdata  <= bus.req_wdata;
                        wait_cnt   <= LAT;
                    end
                end
                WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        rdata_q <= (lat_we || illegal) ? 32'd0 : load_data;
                        err_q   <= illegal;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The array has no reset so an aborted transaction simply never reaches the write.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the same request stream drives a LATENCY=2 and a
// LATENCY=0 instance; per-instance monitors pop expected responses and check latency.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    exp_t q2[$];
    exp_t q0[$];
    exp_t e2;
    exp_t e0;
    logic prev2 = 1'b0;
    logic prev0 = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_if bus2();
    dmem_if bus0();

    assign bus2.req_valid  = req_valid;
    assign bus2.req_we     = req_we;
    assign bus2.req_funct3 = req_funct3;
    assign bus2.req_addr   = req_addr;
    assign bus2.req_wdata  = req_wdata;
    assign bus2.rsp_ready  = rsp_ready;
    assign bus0.req_valid  = req_valid;
    assign bus0.req_we     = req_we;
    assign bus0.req_funct3 = req_funct3;
    assign bus0.req_addr   = req_addr;
    assign bus0.req_wdata  = req_wdata;
    assign bus0.rsp_ready  = rsp_ready;

    dmem_responder #(.ADDR_WIDTH(17), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    dmem_responder #(.ADDR_WIDTH(17), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            prev2 <= 1'b0;
        end else begin
            prev2 <= bus2.rsp_valid;
            if (bus2.rsp_valid && !prev2) checkOutput("latency_L2", 32'(cyc - accept_cyc), 32'd3);
            if (bus2.rsp_valid && rsp_ready) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rsp_L2 actual=response required=none");
                end else begin
                    e2 = q2.pop_front();
                    checkOutput("rdata_L2", bus2.rsp_rdata, e2.rdata);
                    checkOutput("err_L2", {31'd0, bus2.rsp_err}, {31'd0, e2.err});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            prev0 <= 1'b0;
        end else begin
            prev0 <= bus0.rsp_valid;
            if (bus0.rsp_valid && !prev0) checkOutput("latency_L0", 32'(cyc - accept_cyc), 32'd1);
            if (bus0.rsp_valid && rsp_ready) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rsp_L0 actual=response required=none");
                end else begin
                    e0 = q0.pop_front();
                    checkOutput("rdata_L0", bus0.rsp_rdata, e0.rdata);
                    checkOutput("err_L0", {31'd0, bus0.rsp_err}, {31'd0, e0.err});
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        req_valid  = 1'b0;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = ~wdata;
        req_funct3 = 3'b011;
    endtask

    task automatic waitIdle();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            if (q2.size() == 0 && q0.size() == 0 && bus2.req_ready && bus0.req_ready) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout_idle actual=busy required=idle");
        end
    endtask

    task automatic pushExp(input logic [31:0] rdata, input logic err);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        q2.push_back(e);
        q0.push_back(e);
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
        pushExp(exp_rdata, exp_err);
        issue(we, f3, addr, wdata);
        waitIdle();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req_ready_L2", {31'd0, bus2.req_ready}, 32'd1);
        checkOutput("reset_rsp_valid_L2", {31'd0, bus2.rsp_valid}, 32'd0);
        checkOutput("reset_rdata_L2", bus2.rsp_rdata, 32'd0);
        checkOutput("reset_err_L2", {31'd0, bus2.rsp_err}, 32'd0);
        checkOutput("reset_req_ready_L0", {31'd0, bus0.req_ready}, 32'd1);
        checkOutput("reset_rsp_valid_L0", {31'd0, bus0.rsp_valid}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset during WAIT must abandon the store
        applyStimulus(1'b1, 3'b010, 32'h100, 32'h0000_0000, 32'h0, 1'b0);
        issue(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_req_ready_L2", {31'd0, bus2.req_ready}, 32'd1);
        checkOutput("abort_rsp_valid_L2", {31'd0, bus2.rsp_valid}, 32'd0);
        checkOutput("abort_req_ready_L0", {31'd0, bus0.req_ready}, 32'd1);
        checkOutput("abort_rsp_valid_L0", {31'd0, bus0.rsp_valid}, 32'd0);
        applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 32'h0000_0000, 1'b0);

        // Word round trip
        applyStimulus(1'b1, 3'b010, 32'h10, 32'h1234_5678, 32'h0, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_5678, 1'b0);

        // Byte and halfword lanes
        applyStimulus(1'b1, 3'b010, 32'h20, 32'h80FF_7F01, 32'h0, 1'b0);
        applyStimulus(1'b0, 3'b000, 32'h23, 32'h0, 32'hFFFF_FF80, 1'b0);
        applyStimulus(1'b0, 3'b100, 32'h23, 32'h0, 32'h0000_0080, 1'b0);
        applyStimulus(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF_80FF, 1'b0);
        applyStimulus(1'b0, 3'b101, 32'h20, 32'h0, 32'h0000_7F01, 1'b0);
        applyStimulus(1'b1, 3'b000, 32'h21, 32'h1234_56AA, 32'h0, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 32'h80FF_AA01, 1'b0);
        applyStimulus(1'b1, 3'b001, 32'h22, 32'hFFFF_BEEF, 32'h0, 1'b0);
        applyStimulus(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF_BEEF, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEF_AA01, 1'b0);

        // Backpressure: response held, a request pulse during RESP is ignored
        rsp_ready = 1'b0;
        pushExp(32'h1234_5678, 1'b0);
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        for (int i = 0; i < 20 && !(bus2.rsp_valid && bus0.rsp_valid); i++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                req_we     = 1'b1;
                req_funct3 = 3'b010;
                req_addr   = 32'h10;
                req_wdata  = 32'h5555_5555;
                req_valid  = 1'b1;
            end
            if (i == 2) req_valid = 1'b0;
            @(posedge clk);
            #1;
            checkOutput("bp_rsp_valid_L2", {31'd0, bus2.rsp_valid}, 32'd1);
            checkOutput("bp_rdata_L2", bus2.rsp_rdata, 32'h1234_5678);
            checkOutput("bp_req_ready_L2", {31'd0, bus2.req_ready}, 32'd0);
            checkOutput("bp_rsp_valid_L0", {31'd0, bus0.rsp_valid}, 32'd1);
            checkOutput("bp_rdata_L0", bus0.rsp_rdata, 32'h1234_5678);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        waitIdle();
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_5678, 1'b0);

        // Illegal encodings: no write, zero data, error flagged
        applyStimulus(1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b1, 3'b100, 32'h20, 32'hFFFF_FFFF, 32'h0, 1'b1);
        applyStimulus(1'b1, 3'b111, 32'h20, 32'hFFFF_FFFF, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'b110, 32'h20, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEF_AA01, 1'b0);

        // Misaligned accesses
`ifdef DMEM_MISALIGN_CHK_EN
        applyStimulus(1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b1, 3'b010, 32'h23, 32'h1111_1111, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEF_AA01, 1'b0);
        applyStimulus(1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1);
`else
        applyStimulus(1'b0, 3'b010, 32'h22, 32'h0, 32'hBEEF_AA01, 1'b0);
        applyStimulus(1'b1, 3'b010, 32'h23, 32'h1111_1111, 32'h0, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 32'h1111_1111, 1'b0);
        applyStimulus(1'b0, 3'b001, 32'h21, 32'h0, 32'h0000_1111, 1'b0);
`endif

        // Address aliasing above ADDR_WIDTH
        applyStimulus(1'b1, 3'b010, 32'h0002_0000, 32'hCAFE_F00D, 32'h0, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h0000_0000, 32'h0, 32'hCAFE_F00D, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h8002_0010, 32'h0, 32'h1234_5678, 1'b0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
